// File: rtl/wb_dma_pkg.sv
// -----------------------------------------------------------------------------
// wb_dma_pkg
// Shared definitions for the wb_dma_sequencer copy engine: sequencer state
// encodings, the per-word byte increment, the byte-lane selection constant and
// the default watchdog limit.
// -----------------------------------------------------------------------------
package wb_dma_pkg;

  // 3-bit state encodings, kept as named constants so external debug logic
  // can decode the state without depending on the enum type.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE = 3'd1;
  localparam logic [2:0] ST_RD_WAIT  = 3'd2;
  localparam logic [2:0] ST_WR_ISSUE = 3'd3;
  localparam logic [2:0] ST_WR_WAIT  = 3'd4;
  localparam logic [2:0] ST_FINISH   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_RD_ISSUE = ST_RD_ISSUE,
    S_RD_WAIT  = ST_RD_WAIT,
    S_WR_ISSUE = ST_WR_ISSUE,
    S_WR_WAIT  = ST_WR_WAIT,
    S_FINISH   = ST_FINISH
  } state_e;

  // Byte-address step between consecutive 32-bit words.
  localparam int unsigned WORD_INC = 4;

  // Full-word transfers only: all four byte lanes enabled.
  localparam logic [3:0] SEL_ALL = 4'hF;

  // Watchdog limit in cycles when none is given at instantiation.
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/wb_dma_handshake.sv
// -----------------------------------------------------------------------------
// wb_dma_handshake
// Bus handshake helper shared by the read and write phases of the sequencer.
// Generates the registered one-cycle start pulse, detects transaction
// completion (active seen high, then low) and, when WB_DMA_TIMEOUT_EN is
// defined, runs a watchdog over each wait phase.
//
// Ports:
//   i_clk       clock, posedge
//   i_rst_n     synchronous active-low reset
//   i_issue     next cycle is an issue cycle; start is raised for that cycle
//   i_waiting   sequencer is in a wait state this cycle
//   i_active    master busy indicator
//   o_start     registered one-cycle request to the master
//   o_complete  transaction finished this cycle (combinational)
//   o_timeout   watchdog expired this cycle (constant 0 without the macro)
//
// Configuration macro: WB_DMA_TIMEOUT_EN
// -----------------------------------------------------------------------------
module wb_dma_handshake
  import wb_dma_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_issue,
  input  logic i_waiting,
  input  logic i_active,
  output logic o_start,
  output logic o_complete,
  output logic o_timeout
);

  logic r_start;
  logic r_seen_active;
  logic w_complete;

  // start is high exactly during the issue cycle, so it also serves as the
  // "entering a wait state" marker that clears the seen flag and watchdog.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_start       <= 1'b0;
      r_seen_active <= 1'b0;
    end else begin
      r_start <= i_issue;
      if (r_start) begin
        r_seen_active <= 1'b0;
      end else if (i_waiting && i_active) begin
        r_seen_active <= 1'b1;
      end
    end
  end

  // A low active before the master has ever raised it is not a completion;
  // that guards against the cycles before the master reacts to start.
  assign w_complete = i_waiting && r_seen_active && !i_active;
  assign o_complete = w_complete;
  assign o_start    = r_start;

`ifdef WB_DMA_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] r_wd_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_start) begin
      r_wd_cnt <= '0;
    end else if (i_waiting && (r_wd_cnt != WD_LAST)) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // Fires on the TIMEOUT-th wait cycle; a completion in the same cycle wins.
  assign o_timeout = i_waiting && !w_complete && (r_wd_cnt == WD_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign o_timeout        = 1'b0;
`endif

endmodule

// File: rtl/wb_dma_sequencer.sv
// -----------------------------------------------------------------------------
// wb_dma_sequencer
// Memory-to-memory copy engine driving a wb_master_interface. Each word is one
// read from src followed by one write to dst; the master's active/data_rd are
// used as the completion handshake.
//
// Ports:
//   wb_clk, wb_rst       clock and synchronous active-low reset
//   go                   one-cycle job start (accepted only in IDLE)
//   abort                level, checked at each write completion
//   src_addr, dst_addr   word-aligned byte addresses of word 0
//   word_count           number of words to copy (0 allowed)
//   start/address/selection/write/data_wr   request to the master
//   data_rd, active      response from the master
//   busy                 job in progress
//   done                 one-cycle end-of-job pulse
//   words_done           words fully written in the current/last job
//   timeout_err          sticky watchdog flag
//
// Configuration macro: WB_DMA_TIMEOUT_EN (watchdog; timeout_err tied 0 when
// undefined, and a hung slave then stalls the sequencer until reset).
// -----------------------------------------------------------------------------
module wb_dma_sequencer
  import wb_dma_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             go,
  input  logic             abort,
  input  logic [AW-1:0]    src_addr,
  input  logic [AW-1:0]    dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             start,
  output logic [AW-1:0]    address,
  output logic [3:0]       selection,
  output logic             write,
  output logic [DW-1:0]    data_wr,
  input  logic [DW-1:0]    data_rd,
  input  logic             active,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_done,
  output logic             timeout_err
);

  state_e           r_state;
  state_e           w_next;
  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_words_done;
  logic [AW-1:0]    r_address;
  logic             r_write;
  logic [DW-1:0]    r_data_wr;

  logic             w_issue;
  logic             w_waiting;
  logic             w_complete;
  logic             w_timeout;
  logic             w_last;
  logic [AW-1:0]    w_rd_addr;
  logic [AW-1:0]    w_wr_addr;

  // Byte offset of word idx; the address sum wraps modulo 2^AW.
  function automatic logic [AW-1:0] f_word_offset(input logic [CNT_W-1:0] idx);
    return AW'(idx) * AW'(WORD_INC);
  endfunction

  assign w_issue   = (w_next == S_RD_ISSUE) || (w_next == S_WR_ISSUE);
  assign w_waiting = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  assign w_last    = ((r_words_done + CNT_W'(1)) == r_count);

  // A read is entered either from IDLE (word 0, taken straight from the port)
  // or right after word words_done has been written (next word).
  assign w_rd_addr = (r_state == S_IDLE) ? src_addr
                                         : r_src + f_word_offset(r_words_done + CNT_W'(1));
  assign w_wr_addr = r_dst + f_word_offset(r_words_done);

  wb_dma_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_handshake (
    .i_clk      (wb_clk),
    .i_rst_n    (wb_rst),
    .i_issue    (w_issue),
    .i_waiting  (w_waiting),
    .i_active   (active),
    .o_start    (start),
    .o_complete (w_complete),
    .o_timeout  (w_timeout)
  );

  always_comb begin
    // NOTE: w_next is defaulted before the case so every path assigns it and
    // no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (go) begin
          w_next = (word_count == '0) ? S_FINISH : S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (w_complete) begin
          w_next = S_WR_ISSUE;
        end else if (w_timeout) begin
          w_next = S_FINISH;
        end
      end
      S_WR_ISSUE: w_next = S_WR_WAIT;
      S_WR_WAIT: begin
        if (w_complete) begin
          // abort is only looked at here, so a started word always completes.
          w_next = (w_last || abort) ? S_FINISH : S_RD_ISSUE;
        end else if (w_timeout) begin
          w_next = S_FINISH;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_count      <= '0;
      r_words_done <= '0;
      r_address    <= '0;
      r_write      <= 1'b0;
      r_data_wr    <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register here see the same
      // pre-edge values, matching the combinational next-state decode.
      r_state <= w_next;

      if ((r_state == S_IDLE) && go) begin
        r_src        <= src_addr;
        r_dst        <= dst_addr;
        r_count      <= word_count;
        r_words_done <= '0;
      end

      // Request outputs change only when entering an issue state and are
      // otherwise held.
      if (w_next == S_RD_ISSUE) begin
        r_address <= w_rd_addr;
        r_write   <= 1'b0;
      end else if (w_next == S_WR_ISSUE) begin
        r_address <= w_wr_addr;
        r_write   <= 1'b1;
      end

      if ((r_state == S_RD_WAIT) && w_complete) begin
        r_data_wr <= data_rd;
      end

      if ((r_state == S_WR_WAIT) && w_complete) begin
        r_words_done <= r_words_done + CNT_W'(1);
      end
    end
  end

`ifdef WB_DMA_TIMEOUT_EN
  logic r_timeout_err;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      r_timeout_err <= 1'b0;
    end else if ((r_state == S_IDLE) && go) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign address    = r_address;
  assign write      = r_write;
  assign data_wr    = r_data_wr;
  assign selection  = SEL_ALL;
  assign words_done = r_words_done;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FINISH);

endmodule

// File: tb/tb_wb_dma_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wb_dma_sequencer
// Self-checking bench for wb_dma_sequencer. A bus model stands in for the
// master and a sparse memory; a reference model computes the expected copy
// result, transaction list and counters from the job parameters.
// -----------------------------------------------------------------------------
module tb_wb_dma_sequencer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CNT_W = 16;
  localparam int TMO   = 8;

  logic             wb_clk = 1'b0;
  logic             wb_rst = 1'b0;
  logic             go = 1'b0;
  logic             abort;
  logic [AW-1:0]    src_addr = '0;
  logic [AW-1:0]    dst_addr = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic             start;
  logic [AW-1:0]    address;
  logic [3:0]       selection;
  logic             write;
  logic [DW-1:0]    data_wr;
  logic [DW-1:0]    data_rd;
  logic             active;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] words_done;
  logic             timeout_err;

  wb_dma_sequencer #(
    .AW(AW), .DW(DW), .CNT_W(CNT_W), .TIMEOUT(TMO)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .go(go), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .start(start), .address(address), .selection(selection), .write(write),
    .data_wr(data_wr), .data_rd(data_rd), .active(active), .busy(busy),
    .done(done), .words_done(words_done), .timeout_err(timeout_err)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  sel;
  } xact_t;

  xact_t       log_q[$];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int n_total = 0;
  int n_bad   = 0;
  int n_start = 0;
  int n_done  = 0;
  int log_base = 0;
  int abort_word = -1;
  bit abort_force = 0;
  bit abort_hit = 0;
  bit hang = 0;
  int bfm_left = 0;
  logic [31:0] bfm_addr = '0;
  logic        bfm_wr = 1'b0;
  logic [31:0] bfm_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_5A5A);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A_5A5A);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic wait_neg();
    @(negedge wb_clk);
    #1;
  endtask

  // Bus model: master + memory. Holds active for 2..4 cycles per request,
  // returns read data / commits write data when active drops.
  initial begin
    active  = 1'b0;
    data_rd = '0;
    abort   = 1'b0;
    forever begin
      @(negedge wb_clk);
      if (start) n_start++;
      if (done) begin
        n_done++;
        abort_hit = 0;
      end
      if (!wb_rst) begin
        active   = 1'b0;
        bfm_left = 0;
      end else if (hang) begin
        active   = 1'b1;
        bfm_left = 0;
      end else if (bfm_left > 0) begin
        bfm_left--;
        if (bfm_left == 0) begin
          active = 1'b0;
          if (bfm_wr) mem[bfm_addr] = bfm_data;
          else        data_rd = rd_mem(bfm_addr);
        end
      end else if (start) begin
        if (!write && abort_word > 0 && ((log_q.size() - log_base) / 2) == abort_word)
          abort_hit = 1;
        log_q.push_back('{address, write, data_wr, selection});
        bfm_addr = address;
        bfm_wr   = write;
        bfm_data = data_wr;
        active   = 1'b1;
        bfm_left = $urandom_range(2, 4);
      end else begin
        active = 1'b0;
      end
      abort = abort_force || abort_hit;
    end
  end

  // abort_at: -1 none, 0 abort held from IDLE together with go,
  // k>0 abort raised when the read of word k is issued.
  task automatic run_job(input logic [31:0] src, input logic [31:0] dst,
                         input int cnt, input int abort_at);
    int n, cyc, budget, busy_gap, s0, d0, l0;
    logic [31:0] val;
    xact_t exp_q[$];
    n = (abort_at >= 0 && abort_at < cnt) ? abort_at + 1 : cnt;
    for (int i = 0; i < n; i++) begin
      val = ref_rd(src + 32'(4 * i));
      ref_mem[dst + 32'(4 * i)] = val;
      exp_q.push_back('{src + 32'(4 * i), 1'b0, 32'h0, 4'hF});
      exp_q.push_back('{dst + 32'(4 * i), 1'b1, val, 4'hF});
    end
    s0 = n_start; d0 = n_done; l0 = log_q.size();
    log_base   = l0;
    abort_word = (abort_at > 0) ? abort_at : -1;
    if (abort_at == 0) begin
      abort_force = 1;
      wait_neg();
      wait_neg();
      check("idle_abort_busy", busy, 0);
    end
    wait_neg();
    src_addr = src; dst_addr = dst; word_count = CNT_W'(cnt); go = 1'b1;
    wait_neg();
    go = 1'b0;
    src_addr = $urandom(); dst_addr = $urandom(); word_count = CNT_W'($urandom());
    budget = 12 * cnt + 30;
    cyc = 1; busy_gap = 0;
    while (n_done == d0 && cyc < budget) begin
      if (!busy) busy_gap++;
      wait_neg();
      cyc++;
    end
    check("done_seen", n_done - d0, 1);
    check("busy_gap", busy_gap, 0);
    if (cnt == 0) check("zero_latency", cyc, 1);
    wait_neg();
    check("busy_after", busy, 0);
    check("done_once", n_done - d0, 1);
    check("words_done", words_done, n);
    check("start_cycles", n_start - s0, 2 * n);
    check("xact_count", log_q.size() - l0, 2 * n);
    check("timeout_err", timeout_err, 0);
    for (int k = 0; k < 2 * n && (l0 + k) < log_q.size(); k++) begin
      check($sformatf("addr[%0d]", k), log_q[l0 + k].addr, exp_q[k].addr);
      check($sformatf("write[%0d]", k), log_q[l0 + k].wr, exp_q[k].wr);
      check($sformatf("sel[%0d]", k), log_q[l0 + k].sel, exp_q[k].sel);
      if (exp_q[k].wr) check($sformatf("wdata[%0d]", k), log_q[l0 + k].data, exp_q[k].data);
    end
    for (int i = 0; i <= n; i++)
      check($sformatf("mem[%0h]", dst + 32'(4 * i)), rd_mem(dst + 32'(4 * i)), ref_rd(dst + 32'(4 * i)));
    check("mem_size", mem.size(), ref_mem.size());
    abort_force = 0;
    abort_word  = -1;
  endtask

  initial begin
    int l0, cyc, s0, d0;
    logic [31:0] rs, rd;

    repeat (3) wait_neg();
    check("rst_start", start, 0);
    check("rst_write", write, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_address", address, 0);
    check("rst_data_wr", data_wr, 0);
    check("rst_words_done", words_done, 0);
    check("rst_selection", selection, 4'hF);
    check("rst_timeout_err", timeout_err, 0);
    wb_rst = 1'b1;
    wait_neg();

    // Single word.
    preload(32'h2000_0000, 32'hA5A5_B6B6);
    run_job(32'h2000_0000, 32'h3000_0000, 1, -1);
    check("single_word0", rd_mem(32'h3000_0000), 32'hA5A5_B6B6);

    // Burst of 16.
    for (int i = 0; i < 16; i++) preload(32'h2000_0000 + 32'(4 * i), 32'h100 + 32'(i));
    run_job(32'h2000_0000, 32'h3000_0000, 16, -1);

    // Zero count.
    run_job(32'h2000_0000, 32'h3000_0000, 0, -1);

    // Abort during word 4's read: words 0..4 copied, word 5 keeps 0x105.
    for (int i = 0; i < 16; i++) preload(32'h2000_0000 + 32'(4 * i), 32'h200 + 32'(i));
    run_job(32'h2000_0000, 32'h3000_0000, 16, 4);
    check("abort_word5", rd_mem(32'h3000_0014), 32'h105);

    // abort held in IDLE and together with go: go wins, one word copied.
    run_job(32'h2000_0040, 32'h3100_0000, 8, 0);

    // Reset during WR_WAIT of word 2.
    l0 = log_q.size();
    wait_neg();
    src_addr = 32'h2000_0000; dst_addr = 32'h3800_0000; word_count = 16; go = 1'b1;
    wait_neg();
    go = 1'b0;
    cyc = 0;
    while ((log_q.size() - l0) < 6 && cyc < 200) begin
      wait_neg();
      cyc++;
    end
    check("mid_reset_reached", log_q.size() - l0, 6);
    wait_neg();
    wb_rst = 1'b0;
    wait_neg();
    check("mid_reset_busy", busy, 0);
    check("mid_reset_start", start, 0);
    check("mid_reset_words_done", words_done, 0);
    check("mid_reset_done", done, 0);
    wb_rst = 1'b1;
    for (int i = 0; i < 2; i++) ref_mem[32'h3800_0000 + 32'(4 * i)] = ref_rd(32'h2000_0000 + 32'(4 * i));
    for (int i = 0; i < 3; i++)
      check($sformatf("mid_reset_mem%0d", i), rd_mem(32'h3800_0000 + 32'(4 * i)),
            ref_rd(32'h3800_0000 + 32'(4 * i)));
    wait_neg();
    run_job(32'h2000_0000, 32'h3200_0000, 1, -1);

`ifdef WB_DMA_TIMEOUT_EN
    // Hung slave: active stuck high.
    hang = 1;
    s0 = n_start; d0 = n_done;
    wait_neg();
    src_addr = 32'h2000_0000; dst_addr = 32'h3300_0000; word_count = 3; go = 1'b1;
    wait_neg();
    go = 1'b0;
    cyc = 1;
    while (n_done == d0 && cyc < 40) begin
      wait_neg();
      cyc++;
    end
    check("tmo_latency", cyc, 10);
    check("tmo_flag", timeout_err, 1);
    check("tmo_words_done", words_done, 0);
    check("tmo_starts", n_start - s0, 1);
    hang = 0;
    wait_neg();
    wait_neg();
    check("tmo_sticky", timeout_err, 1);
    run_job(32'h2000_0000, 32'h3300_0000, 1, -1);
`endif

    // Randomized jobs, some wrapping past the top of the address space.
    for (int j = 0; j < 12; j++) begin
      int cnt, ab;
      rs = $urandom();
      rd = $urandom();
      rs[1:0] = 2'b00;
      rd[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) rs = 32'hFFFF_FFC0 + 32'(4 * $urandom_range(0, 15));
      for (int i = 0; i < 4; i++) preload(rs + 32'(4 * i), $urandom());
      cnt = $urandom_range(0, 20);
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : -1;
      run_job(rs, rd, cnt, ab);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
